// File: rtl/rr_selector.sv
// rr_selector: N-channel packet arbiter (fixed-priority or round-robin) with a hold watchdog.
// Ports: clk, rst (sync, active-high); req/tail [N-1:0] per-channel request and last-flit marker;
//        ready downstream accept; select one-hot grant, idx its binary index, valid grant present,
//        timeout one-cycle pulse on watchdog-forced release. All outputs are registered.
module rr_selector #(
    parameter int N        = 5,
    parameter int MODE     = 1,
    parameter int MAX_HOLD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         tail,
    input  logic                 ready,
    output logic [N-1:0]         select,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid,
    output logic                 timeout
);
    localparam int IW = $clog2(N);
    localparam int HW = MAX_HOLD > 0 ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_n;
    logic [IW-1:0] ptr, win, cand;
    logic [HW-1:0] hold;
    logic          found, done, wd, rel;

    // Scan upward from ptr (round-robin) or from 0 (fixed priority), wrapping at N-1.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = MODE != 0 ? ptr : '0;
        for (int o = 0; o < N; o++) begin
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
            cand = cand == IW'(N - 1) ? '0 : cand + IW'(1);
        end
    end

    // Watchdog fires on the BUSY cycle that would bring the hold count to MAX_HOLD,
    // unless the packet is ending or aborting in that same cycle.
    always_comb begin
        done    = state == BUSY && ready && tail[idx];
        wd      = MAX_HOLD != 0 && state == BUSY && !done && req[idx] && hold == HW'(MAX_HOLD - 1);
        rel     = state == BUSY && (done || !req[idx] || wd);
        state_n = state == IDLE ? (found ? BUSY : IDLE) : (rel ? IDLE : BUSY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            select  <= '0;
            idx     <= '0;
            valid   <= 1'b0;
            timeout <= 1'b0;
            ptr     <= '0;
            hold    <= '0;
        end else begin
            state   <= state_n;
            timeout <= wd;
            if (state == IDLE && found) begin
                select <= N'(1) << win;
                idx    <= win;
                valid  <= 1'b1;
                ptr    <= win == IW'(N - 1) ? '0 : win + IW'(1);
                hold   <= '0;
            end else if (rel) begin
                select <= '0;
                idx    <= '0;
                valid  <= 1'b0;
            end else if (state == BUSY && MAX_HOLD != 0 && hold != HW'(MAX_HOLD)) begin
                hold <= hold + HW'(1);
            end
        end
    end
endmodule

// File: tb/tb_rr_selector.sv
// tb_rr_selector: scoreboard bench for a round-robin (MAX_HOLD=4) and a fixed-priority rr_selector.
module tb_rr_selector;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] req[2], tail[2], sel[2];
    logic       ready[2], valid[2], timeout[2];
    logic [2:0] idx[2];

    typedef struct {
        int dut;
        int ch;
        int gap;
        int len;
        bit to;
    } item_t;

    item_t sb[$];
    int    vectors = 0;
    int    errors  = 0;
    bit    go      = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : m
        rr_selector #(.N(5), .MODE(g == 0 ? 1 : 0), .MAX_HOLD(g == 0 ? 4 : 0)) dut (
            .clk(clk), .rst(rst), .req(req[g]), .tail(tail[g]), .ready(ready[g]),
            .select(sel[g]), .idx(idx[g]), .valid(valid[g]), .timeout(timeout[g])
        );

        int    hi = 0;
        int    lo = 0;
        logic  pv = 1'b0;
        item_t it;

        always @(negedge clk) if (go) begin
            vectors++;
            if ((valid[g] ? sel[g] !== 5'b1 << idx[g] : (sel[g] !== 5'b0 || idx[g] !== 3'd0))
                || (timeout[g] !== 1'b0 && !(pv && !valid[g]))) begin
                errors++;
                $display("FAIL invariant dut%0d: got valid=%b select=%b idx=%0d timeout=%b, want one-hot select matching idx, timeout only on release",
                         g, valid[g], sel[g], idx[g], timeout[g]);
            end
            if (valid[g] && !pv) begin
                vectors++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL grant dut%0d: got ch%0d, want no grant", g, idx[g]);
                end else if (sb[0].dut != g || idx[g] !== 3'(sb[0].ch) || (sb[0].gap >= 0 && lo != sb[0].gap)) begin
                    errors++;
                    $display("FAIL grant dut%0d: got ch%0d gap %0d, want dut%0d ch%0d gap %0d",
                             g, idx[g], lo, sb[0].dut, sb[0].ch, sb[0].gap);
                end
            end
            if (!valid[g] && pv) begin
                vectors++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL release dut%0d: got release, want none pending", g);
                end else begin
                    it = sb.pop_front();
                    if (hi != it.len || timeout[g] !== it.to) begin
                        errors++;
                        $display("FAIL release dut%0d ch%0d: got len %0d timeout %b, want len %0d timeout %b",
                                 g, it.ch, hi, timeout[g], it.len, it.to);
                    end
                end
            end
            hi = valid[g] ? hi + 1 : 0;
            lo = valid[g] ? 0 : lo + 1;
            pv = valid[g];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input int ch, input int gap, input int len, input bit to);
        item_t i;
        i.dut = d;
        i.ch  = ch;
        i.gap = gap;
        i.len = len;
        i.to  = to;
        sb.push_back(i);
    endtask

    task automatic drive(input int d, input logic [4:0] r, input logic [4:0] t, input logic rd);
        req[d]   = r;
        tail[d]  = t;
        ready[d] = rd;
    endtask

    task automatic chk(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) drive(d, 5'b0, 5'b0, 1'b0);
        repeat (2) tick;
        for (int d = 0; d < 2; d++) begin
            chk("reset_select", int'(sel[d]), 0);
            chk("reset_idx", int'(idx[d]), 0);
            chk("reset_valid", int'(valid[d]), 0);
            chk("reset_timeout", int'(timeout[d]), 0);
        end
        rst = 1'b0;
        go  = 1'b1;
        tick;

        // Round-robin over 10101 with single-cycle packets: 0,2,4,0 each after one bubble.
        push(0, 0, -1, 1, 0); push(0, 2, 1, 1, 0); push(0, 4, 1, 1, 0); push(0, 0, 1, 1, 0);
        drive(0, 5'b10101, 5'b11111, 1'b1);
        repeat (7) tick;
        drive(0, 5'b0, 5'b11111, 1'b1);
        tick;
        drive(0, 5'b0, 5'b0, 1'b0);
        tick;

        // tail high while ready low: held until ready rises (ptr=1 -> ch1).
        push(0, 1, -1, 3, 0);
        drive(0, 5'b00010, 5'b00010, 1'b0);
        repeat (3) tick;
        ready[0] = 1'b1;
        tick;
        drive(0, 5'b0, 5'b0, 1'b0);
        tick;

        // Abort of ch3 with ch1 waiting: release, one bubble, then ch1.
        push(0, 3, -1, 2, 0); push(0, 1, 1, 1, 0);
        drive(0, 5'b01000, 5'b0, 1'b0);
        repeat (2) tick;
        req[0] = 5'b00010;
        repeat (2) tick;
        drive(0, 5'b00010, 5'b00010, 1'b1);
        tick;
        drive(0, 5'b0, 5'b0, 1'b0);
        tick;

        // Watchdog: ch1 never sees its own tail (other tails ignored) -> forced release after 4 cycles.
        push(0, 1, -1, 4, 1);
        drive(0, 5'b00010, 5'b11101, 1'b1);
        repeat (5) tick;
        drive(0, 5'b0, 5'b0, 1'b0);
        repeat (2) tick;

        // Reset mid-grant on ch4, then ptr restarts at 0 -> ch0 wins 10001.
        push(0, 4, -1, 2, 0); push(0, 0, 1, 1, 0);
        drive(0, 5'b10000, 5'b0, 1'b0);
        repeat (2) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        req[0] = 5'b10001;
        tick;
        drive(0, 5'b10001, 5'b00001, 1'b1);
        tick;
        drive(0, 5'b0, 5'b0, 1'b0);
        repeat (2) tick;

        // Fixed priority: ch0 every time over 10101.
        push(1, 0, -1, 1, 0); push(1, 0, 1, 1, 0); push(1, 0, 1, 1, 0); push(1, 0, 1, 1, 0);
        drive(1, 5'b10101, 5'b11111, 1'b1);
        repeat (7) tick;
        drive(1, 5'b0, 5'b11111, 1'b1);
        tick;
        drive(1, 5'b0, 5'b0, 1'b0);
        tick;

        // Fixed priority lowest wins on 01010.
        push(1, 1, -1, 1, 0);
        drive(1, 5'b01010, 5'b11111, 1'b1);
        tick;
        drive(1, 5'b0, 5'b11111, 1'b1);
        tick;
        drive(1, 5'b0, 5'b0, 1'b0);
        tick;

        // No watchdog with MAX_HOLD=0: ch2 held 6 cycles, then abort hands over to ch0.
        push(1, 2, -1, 6, 0); push(1, 0, 1, 1, 0);
        drive(1, 5'b00100, 5'b0, 1'b0);
        repeat (6) tick;
        req[1] = 5'b00001;
        repeat (2) tick;
        drive(1, 5'b00001, 5'b00001, 1'b1);
        tick;
        drive(1, 5'b0, 5'b0, 1'b0);
        repeat (3) tick;

        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
